soc_event_collector: RTL and testbench

- Upstream neighbour of the APB interrupt controller's event FIFO input.
- Collects single-cycle event pulses from NB_EVENTS peripheral sources and keeps a saturating pending count per source.
- Serialises pending events as event IDs onto a valid/grant push interface. That interface connects directly to the controller's event_fifo_valid_i / event_fifo_fulln_o / event_fifo_data_i.
- Per-source overflow flags record events lost to counter saturation.

---
 rtl/soc_event_collector.sv | 136 +++++++++++++
 tb/tb_soc_event_collector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/soc_event_collector.sv
// Per-source saturating event counters serialised as event IDs onto a valid/grant push port.
// Optional macro SOC_EVT_COLLECTOR_FIXED_PRIO_EN selects fixed (lowest index) priority instead of round-robin.
module soc_event_collector #(
  parameter int NB_EVENTS    = 16,
  parameter int EVT_ID_WIDTH = 8,
  parameter int EVT_ID_BASE  = 0,
  parameter int CNT_WIDTH    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NB_EVENTS-1:0]    events_i,
  input  logic [NB_EVENTS-1:0]    evt_mask_i,
  output logic                    event_fifo_valid_o,
  input  logic                    event_fifo_fulln_i,
  output logic [EVT_ID_WIDTH-1:0] event_fifo_data_o,
  output logic [NB_EVENTS-1:0]    ovf_o,
  input  logic [NB_EVENTS-1:0]    ovf_clr_i,
  output logic                    busy_o
);

  localparam int PTR_W = $clog2(NB_EVENTS);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0]    r_cnt [NB_EVENTS];
  logic                    r_valid;
  logic [EVT_ID_WIDTH-1:0] r_data;
  logic [NB_EVENTS-1:0]    r_ovf;

  logic [NB_EVENTS-1:0] w_req;
  logic [NB_EVENTS-1:0] w_sat;
  logic [NB_EVENTS-1:0] w_inc;
  logic [NB_EVENTS-1:0] w_dec;
  logic [NB_EVENTS-1:0] w_ovf_set;
  logic                 w_xfer;
  logic                 w_load;
  logic                 w_take;
  logic                 w_gnt_vld;
  logic [PTR_W-1:0]     w_gnt_idx;

  always_comb begin
    w_req = '0;
    w_sat = '0;
    for (int i = 0; i < NB_EVENTS; i++) begin
      w_req[i] = (r_cnt[i] != '0);
      w_sat[i] = (r_cnt[i] == CNT_MAX);
    end
  end

  assign w_inc  = events_i & evt_mask_i;
  assign w_xfer = r_valid & event_fifo_fulln_i;
  assign w_load = ~r_valid | w_xfer;
  assign w_take = w_load & w_gnt_vld;

`ifdef SOC_EVT_COLLECTOR_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last one assigned.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = NB_EVENTS - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] r_ptr;

  function automatic int rr_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NB_EVENTS) ? s - NB_EVENTS : s;
  endfunction

  // Descending offset scan: the requester closest above r_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int j = NB_EVENTS - 1; j >= 0; j--) begin
      if (w_req[rr_idx(int'(r_ptr), j)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PTR_W'(rr_idx(int'(r_ptr), j));
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= (int'(w_gnt_idx) == NB_EVENTS - 1) ? '0 : w_gnt_idx + PTR_W'(1);
    end
  end
`endif

  always_comb begin
    w_dec = '0;
    if (w_take) w_dec[w_gnt_idx] = 1'b1;
  end

  assign w_ovf_set = w_inc & ~w_dec & w_sat;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_EVENTS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB_EVENTS; i++) begin
        if (w_inc[i] && !w_dec[i] && !w_sat[i]) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
        else if (!w_inc[i] && w_dec[i])        r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
      end
    end
  end

  // Set wins over clear on the same bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_ovf <= '0;
    else       r_ovf <= (r_ovf & ~ovf_clr_i) | w_ovf_set;
  end

  // Data only moves on a load, so it is stable for as long as valid waits for grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= w_gnt_vld;
      if (w_gnt_vld) r_data <= EVT_ID_WIDTH'(EVT_ID_BASE + int'(w_gnt_idx));
    end
  end

  assign event_fifo_valid_o = r_valid;
  assign event_fifo_data_o  = r_data;
  assign ovf_o              = r_ovf;
  assign busy_o             = r_valid | (|w_req);

endmodule

// File: tb/tb_soc_event_collector.sv
// Directed self-checking bench for soc_event_collector (default parameters).
// Honours SOC_EVT_COLLECTOR_FIXED_PRIO_EN for the arbitration-order expectations.
module tb_soc_event_collector;

  localparam int NB = 16;
  localparam int IW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [NB-1:0] events_i;
  logic [NB-1:0] evt_mask_i;
  logic          event_fifo_valid_o;
  logic          event_fifo_fulln_i;
  logic [IW-1:0] event_fifo_data_o;
  logic [NB-1:0] ovf_o;
  logic [NB-1:0] ovf_clr_i;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  soc_event_collector #(.NB_EVENTS(NB), .EVT_ID_WIDTH(IW), .EVT_ID_BASE(0), .CNT_WIDTH(2)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .events_i           (events_i),
    .evt_mask_i         (evt_mask_i),
    .event_fifo_valid_o (event_fifo_valid_o),
    .event_fifo_fulln_i (event_fifo_fulln_i),
    .event_fifo_data_o  (event_fifo_data_o),
    .ovf_o              (ovf_o),
    .ovf_clr_i          (ovf_clr_i),
    .busy_o             (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    #1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    events_i = '0;
    evt_mask_i = '1;
    event_fifo_fulln_i = 1'b1;
    ovf_clr_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
    n_tests++; if (event_fifo_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", event_fifo_valid_o); end
    n_tests++; if (event_fifo_data_o !== 8'd0) begin n_fail++; $display("FAIL reset_data got=%0d exp=0", event_fifo_data_o); end
    n_tests++; if (ovf_o !== 16'h0) begin n_fail++; $display("FAIL reset_ovf got=%h exp=0", ovf_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_single();
    evt_mask_i = '1;
    event_fifo_fulln_i = 1'b1;
    events_i = 16'h0008;
    tick();
    events_i = '0;
    n_tests++; if (event_fifo_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b exp=0", event_fifo_valid_o); end
    n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy_pending got=%b exp=1", busy_o); end
    tick();
    n_tests++; if (event_fifo_valid_o !== 1'b1 || event_fifo_data_o !== 8'd3) begin n_fail++; $display("FAIL single_emit got v=%b d=%0d exp v=1 d=3", event_fifo_valid_o, event_fifo_data_o); end
    tick();
    n_tests++; if (event_fifo_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle got v=%b busy=%b exp 0 0", event_fifo_valid_o, busy_o); end
    n_tests++; if (event_fifo_data_o !== 8'd3) begin n_fail++; $display("FAIL single_data_keep got=%0d exp=3", event_fifo_data_o); end
  endtask

  task automatic test_backpressure();
    event_fifo_fulln_i = 1'b0;
    events_i = 16'h0006;
    tick();
    events_i = '0;
    tick();
    for (int c = 0; c < 10; c++) begin
      n_tests++; if (event_fifo_valid_o !== 1'b1 || event_fifo_data_o !== 8'd1) begin n_fail++; $display("FAIL bp_hold cyc=%0d got v=%b d=%0d exp v=1 d=1", c, event_fifo_valid_o, event_fifo_data_o); end
      tick();
    end
    event_fifo_fulln_i = 1'b1;
    tick();
    n_tests++; if (event_fifo_valid_o !== 1'b1 || event_fifo_data_o !== 8'd2) begin n_fail++; $display("FAIL bp_second got v=%b d=%0d exp v=1 d=2", event_fifo_valid_o, event_fifo_data_o); end
    tick();
    n_tests++; if (event_fifo_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain got v=%b exp=0", event_fifo_valid_o); end
  endtask

  task automatic test_arbitration();
    logic [IW-1:0] exp_ids [9];
`ifdef SOC_EVT_COLLECTOR_FIXED_PRIO_EN
    exp_ids = '{8'd0, 8'd0, 8'd0, 8'd5, 8'd5, 8'd5, 8'd9, 8'd9, 8'd9};
`else
    exp_ids = '{8'd0, 8'd5, 8'd9, 8'd0, 8'd5, 8'd9, 8'd0, 8'd5, 8'd9};
`endif
    apply_reset();
    event_fifo_fulln_i = 1'b0;
    events_i = 16'h0221;
    tick();
    tick();
    tick();
    events_i = '0;
    event_fifo_fulln_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      n_tests++; if (event_fifo_valid_o !== 1'b1 || event_fifo_data_o !== exp_ids[k]) begin n_fail++; $display("FAIL arb_order k=%0d got v=%b d=%0d exp v=1 d=%0d", k, event_fifo_valid_o, event_fifo_data_o, exp_ids[k]); end
      tick();
    end
    n_tests++; if (event_fifo_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL arb_end got v=%b busy=%b exp 0 0", event_fifo_valid_o, busy_o); end
  endtask

  task automatic test_saturation();
    int seen;
    event_fifo_fulln_i = 1'b0;
    events_i = 16'h0080;
    for (int c = 0; c < 5; c++) tick();
    events_i = '0;
    n_tests++; if (event_fifo_valid_o !== 1'b1 || event_fifo_data_o !== 8'd7) begin n_fail++; $display("FAIL sat_head got v=%b d=%0d exp v=1 d=7", event_fifo_valid_o, event_fifo_data_o); end
    n_tests++; if (ovf_o !== 16'h0080) begin n_fail++; $display("FAIL sat_ovf got=%h exp=0080", ovf_o); end
    event_fifo_fulln_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (event_fifo_valid_o === 1'b1 && event_fifo_data_o === 8'd7) seen++;
      tick();
    end
    n_tests++; if (seen !== 4) begin n_fail++; $display("FAIL sat_count got=%0d exp=4", seen); end
    n_tests++; if (ovf_o !== 16'h0080) begin n_fail++; $display("FAIL sat_ovf_sticky got=%h exp=0080", ovf_o); end
    ovf_clr_i = 16'h0080;
    tick();
    ovf_clr_i = '0;
    n_tests++; if (ovf_o !== 16'h0000) begin n_fail++; $display("FAIL sat_ovf_clr got=%h exp=0000", ovf_o); end
  endtask

  task automatic test_simultaneous();
    int seen;
    event_fifo_fulln_i = 1'b1;
    events_i = 16'h0010;
    tick();
    tick();
    events_i = '0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (event_fifo_valid_o === 1'b1 && event_fifo_data_o === 8'd4) seen++;
      tick();
    end
    n_tests++; if (seen !== 2) begin n_fail++; $display("FAIL incdec_count got=%0d exp=2", seen); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL incdec_idle got busy=%b exp=0", busy_o); end
    event_fifo_fulln_i = 1'b0;
    events_i = 16'h0040;
    for (int c = 0; c < 4; c++) tick();
    n_tests++; if (ovf_o !== 16'h0000) begin n_fail++; $display("FAIL setclr_pre got=%h exp=0000", ovf_o); end
    ovf_clr_i = 16'h0040;
    tick();
    events_i = '0;
    ovf_clr_i = '0;
    n_tests++; if (ovf_o !== 16'h0040) begin n_fail++; $display("FAIL setclr_setwins got=%h exp=0040", ovf_o); end
    event_fifo_fulln_i = 1'b1;
    ovf_clr_i = 16'h0040;
    for (int c = 0; c < 6; c++) tick();
    ovf_clr_i = '0;
    n_tests++; if (ovf_o !== 16'h0000 || busy_o !== 1'b0) begin n_fail++; $display("FAIL setclr_cleanup got ovf=%h busy=%b exp 0000 0", ovf_o, busy_o); end
  endtask

  task automatic test_mask_reset();
    int seen;
    evt_mask_i = ~16'h0004;
    event_fifo_fulln_i = 1'b1;
    events_i = 16'h0004;
    tick();
    events_i = '0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (event_fifo_valid_o === 1'b1 || busy_o === 1'b1) seen++;
      tick();
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL mask_drop got active_cycles=%0d exp=0", seen); end
    evt_mask_i = '1;
    event_fifo_fulln_i = 1'b0;
    events_i = 16'h0100;
    for (int c = 0; c < 4; c++) tick();
    events_i = '0;
    n_tests++; if (event_fifo_valid_o !== 1'b1 || event_fifo_data_o !== 8'd8) begin n_fail++; $display("FAIL rst_pre got v=%b d=%0d exp v=1 d=8", event_fifo_valid_o, event_fifo_data_o); end
    rst_i = 1'b1;
    #1;
    n_tests++; if (event_fifo_valid_o !== 1'b0 || event_fifo_data_o !== 8'd0 || ovf_o !== 16'h0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_async got v=%b d=%0d ovf=%h busy=%b exp all 0", event_fifo_valid_o, event_fifo_data_o, ovf_o, busy_o); end
    tick();
    rst_i = 1'b0;
    event_fifo_fulln_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (event_fifo_valid_o === 1'b1) seen++;
      tick();
    end
    n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_emit got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_arbitration();
    test_saturation();
    test_simultaneous();
    test_mask_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
